// File: rtl/zigbee_pkg.sv
// Shared definitions for the zigbee_top datapath.
// Holds the DEMUX target encodings, the QPSK symbol constants, the CORDIC
// arctangent table (1/256-turn units), the phase width and the serializer FSM.
package zigbee_pkg;

   // DEMUX1 targets
   localparam logic [2:0] SEL1_DEC_EOC   = 3'b000;
   localparam logic [2:0] SEL1_COD_DATA  = 3'b001;
   localparam logic [2:0] SEL1_IN_RE     = 3'b010;

   // DEMUX2 targets
   localparam logic [2:0] SEL2_IN_WE     = 3'b000;
   localparam logic [2:0] SEL2_COD_EMPTY = 3'b001;
   localparam logic [2:0] SEL2_COR_EN    = 3'b010;

   // QPSK amplitudes: bit 1 -> +7, bit 0 -> -7
   localparam logic [3:0] QPSK_POS = 4'b0111;
   localparam logic [3:0] QPSK_NEG = 4'b1001;

   localparam int PHASE_W = 4;
   localparam int COR_W   = 8;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_LOAD,
      SER_SHIFT
   } ser_state_e;

   // atan(2^-i) in 1/256 turn; entries past 3 allow CORDIC_ITER up to 8
   function automatic logic [COR_W-1:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:    atan_lut = 8'd32;
         4'd1:    atan_lut = 8'd19;
         4'd2:    atan_lut = 8'd10;
         4'd3:    atan_lut = 8'd5;
         4'd4:    atan_lut = 8'd3;
         4'd5:    atan_lut = 8'd1;
         4'd6:    atan_lut = 8'd1;
         default: atan_lut = 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/zigbee_top_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port.
// Ports: clk, rst (sync active-high), we/din write side, re read side,
//        dout (updates only on an accepted read), full, empty.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [W-1:0] din,
   input  logic         re,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          do_wr, do_rd;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = dout_q;

   always_comb begin
      // a write into a full FIFO is dropped even if a read frees a slot
      do_wr  = we & ~full;
      do_rd  = re & ~empty;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      dout_d = dout_q;
      cnt_d  = cnt_q;
      if (do_wr) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_rd) begin
         dout_d = mem_q[rptr_q];
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: rtl/zigbee_top.sv
// zigbee_top: inFIFO -> serializer -> QPSK coder -> decoder -> outFIFO, with a
// CORDIC phase estimator hanging off the coder I/Q. DEMUX overrides let any
// stage be driven directly; MUX outputs expose internal state.
// Ports: inClock/inReset (sync active-high); in_inFIFO_inData write nibble;
//        in_outFIFO_inReadEnable outFIFO pop; in_DEMUX_* override values and
//        target selects; in_MUX_inSEL3 chained/standalone; in_MUX_inSEL* pick
//        what appears on out_MUX_outMUX9/10 (4-bit) and outMUX15/16 (1-bit).
module zigbee_top
   import zigbee_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int CORDIC_ITER = 4
) (
   input  logic       inClock,
   input  logic       inReset,
   input  logic [3:0] in_inFIFO_inData,
   input  logic       in_outFIFO_inReadEnable,
   input  logic       in_DEMUX_inDEMUX1,
   input  logic       in_DEMUX_inDEMUX2,
   input  logic [3:0] in_DEMUX_inDEMUX17,
   input  logic [3:0] in_DEMUX_inDEMUX18,
   input  logic [2:0] in_DEMUX_inSEL1,
   input  logic [2:0] in_DEMUX_inSEL2,
   input  logic       in_MUX_inSEL3,
   input  logic       in_DEMUX_inSEL17,
   input  logic [1:0] in_MUX_inSEL9,
   input  logic [1:0] in_MUX_inSEL6,
   input  logic [2:0] in_MUX_inSEL15,
   input  logic       in_MUX_inSEL11,
   input  logic       in_MUX_inSEL12,
   output logic [3:0] out_MUX_outMUX9,
   output logic [3:0] out_MUX_outMUX10,
   output logic       out_MUX_outMUX15,
   output logic       out_MUX_outMUX16
);

   // ---------------- override routing ----------------
   logic standalone;
   logic ovr_dec_eoc, ovr_cod_data, ovr_in_re;
   logic ovr_in_we, ovr_cod_empty, ovr_cor_en;
   logic sel_cod_empty;

   assign standalone    = in_MUX_inSEL3;
   assign ovr_dec_eoc   = (in_DEMUX_inSEL1 == SEL1_DEC_EOC)  & in_DEMUX_inDEMUX1;
   assign ovr_cod_data  = (in_DEMUX_inSEL1 == SEL1_COD_DATA) & in_DEMUX_inDEMUX1;
   assign ovr_in_re     = (in_DEMUX_inSEL1 == SEL1_IN_RE)    & in_DEMUX_inDEMUX1;
   assign ovr_in_we     = (in_DEMUX_inSEL2 == SEL2_IN_WE)    & in_DEMUX_inDEMUX2;
   assign sel_cod_empty = (in_DEMUX_inSEL2 == SEL2_COD_EMPTY);
   assign ovr_cod_empty = sel_cod_empty & in_DEMUX_inDEMUX2;
   assign ovr_cor_en    = (in_DEMUX_inSEL2 == SEL2_COR_EN)   & in_DEMUX_inDEMUX2;

   // ---------------- state ----------------
   ser_state_e ser_state_q, ser_state_d;
   logic [3:0] ser_sh_q, ser_sh_d;
   logic [1:0] ser_cnt_q, ser_cnt_d;
   logic       ser_pop, ser_bit, ser_empty;

   logic       cod_cnt_q, cod_cnt_d, cod_first_q, cod_first_d, cod_eoc_q, cod_eoc_d;
   logic [3:0] cod_i_q, cod_i_d, cod_q_q, cod_q_d;

   logic       dec_cnt_q, dec_cnt_d, dec_vld_q, dec_vld_d;
   logic [1:0] dec_hi_q, dec_hi_d, dec_sym;
   logic [3:0] dec_nib_q, dec_nib_d;

   logic                    cor_busy_q, cor_busy_d, cor_vld_q, cor_vld_d;
   logic [3:0]              cor_step_q, cor_step_d;
   logic signed [COR_W-1:0] cor_x_q, cor_x_d, cor_y_q, cor_y_d, cor_xi, cor_yi;
   logic [COR_W-1:0]        cor_z_q, cor_z_d, cor_zr;
   logic [PHASE_W-1:0]      cor_ph_q, cor_ph_d;

   // ---------------- effective stage inputs ----------------
   // In chained mode a selected override can only assert its target, so an
   // idle override leaves the chain intact; standalone mode cuts the chain.
   logic       in_we, in_re, cod_data, cod_empty, dec_eoc, cor_en;
   logic [3:0] dec_i, dec_q, cor_i, cor_q;

   always_comb begin
      in_we = ovr_in_we;
      if (standalone) begin
         in_re     = ovr_in_re;
         cod_data  = ovr_cod_data;
         cod_empty = sel_cod_empty ? in_DEMUX_inDEMUX2 : 1'b1;
         dec_eoc   = ovr_dec_eoc;
         cor_en    = ovr_cor_en;
         dec_i     = in_DEMUX_inSEL17 ? 4'd0 : in_DEMUX_inDEMUX17;
         dec_q     = in_DEMUX_inSEL17 ? 4'd0 : in_DEMUX_inDEMUX18;
         cor_i     = in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX17 : 4'd0;
         cor_q     = in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX18 : 4'd0;
      end else begin
         in_re     = ser_pop | ovr_in_re;
         cod_data  = ser_bit | ovr_cod_data;
         cod_empty = ser_empty | ovr_cod_empty;
         dec_eoc   = cod_eoc_q | ovr_dec_eoc;
         cor_en    = cod_eoc_q | ovr_cor_en;
         dec_i     = cod_i_q;
         dec_q     = cod_q_q;
         cor_i     = cod_i_q;
         cor_q     = cod_q_q;
      end
   end

   // ---------------- FIFOs ----------------
   logic       in_full, in_empty, out_full, out_empty;
   logic [3:0] in_dout, out_dout;

   sync_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_in_fifo (
      .clk(inClock), .rst(inReset), .we(in_we), .din(in_inFIFO_inData),
      .re(in_re), .dout(in_dout), .full(in_full), .empty(in_empty)
   );

   sync_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_out_fifo (
      .clk(inClock), .rst(inReset), .we(dec_vld_q), .din(dec_nib_q),
      .re(in_outFIFO_inReadEnable), .dout(out_dout), .full(out_full), .empty(out_empty)
   );

   // ---------------- serializer ----------------
   // Pop, wait one cycle for the registered FIFO output, then shift MSB-first.
   always_comb begin
      ser_state_d = ser_state_q;
      ser_sh_d    = ser_sh_q;
      ser_cnt_d   = ser_cnt_q;
      ser_pop     = 1'b0;
      ser_bit     = 1'b0;
      ser_empty   = 1'b1;
      case (ser_state_q)
         SER_IDLE: begin
            if (!standalone && !in_empty) begin
               ser_pop     = 1'b1;
               ser_state_d = SER_LOAD;
            end
         end
         SER_LOAD: begin
            ser_sh_d    = in_dout;
            ser_cnt_d   = 2'd0;
            ser_state_d = SER_SHIFT;
         end
         SER_SHIFT: begin
            ser_empty = 1'b0;
            ser_bit   = ser_sh_q[3];
            ser_sh_d  = {ser_sh_q[2:0], 1'b0};
            ser_cnt_d = ser_cnt_q + 2'd1;
            if (ser_cnt_q == 2'd3) ser_state_d = SER_IDLE;
         end
         default: ser_state_d = SER_IDLE;
      endcase
   end

   // ---------------- coder ----------------
   always_comb begin
      cod_cnt_d   = cod_cnt_q;
      cod_first_d = cod_first_q;
      cod_i_d     = cod_i_q;
      cod_q_d     = cod_q_q;
      cod_eoc_d   = 1'b0;
      if (!cod_empty) begin
         if (!cod_cnt_q) begin
            cod_first_d = cod_data;
            cod_cnt_d   = 1'b1;
         end else begin
            cod_i_d   = cod_first_q ? QPSK_POS : QPSK_NEG;
            cod_q_d   = cod_data    ? QPSK_POS : QPSK_NEG;
            cod_eoc_d = 1'b1;
            cod_cnt_d = 1'b0;
         end
      end
   end

   // ---------------- decoder ----------------
   always_comb begin
      dec_sym   = {~dec_i[3], ~dec_q[3]};
      dec_cnt_d = dec_cnt_q;
      dec_hi_d  = dec_hi_q;
      dec_nib_d = dec_nib_q;
      dec_vld_d = 1'b0;
      if (dec_eoc) begin
         if (!dec_cnt_q) begin
            dec_hi_d  = dec_sym;
            dec_cnt_d = 1'b1;
         end else begin
            dec_nib_d = {dec_hi_q, dec_sym};
            dec_vld_d = 1'b1;
            dec_cnt_d = 1'b0;
         end
      end
   end

   // ---------------- CORDIC ----------------
   // Capture (with pre-rotation into the right half-plane), CORDIC_ITER
   // micro-rotations, then one cycle to round z to the 22.5 degree grid.
   always_comb begin
      cor_busy_d = cor_busy_q;
      cor_step_d = cor_step_q;
      cor_x_d    = cor_x_q;
      cor_y_d    = cor_y_q;
      cor_z_d    = cor_z_q;
      cor_ph_d   = cor_ph_q;
      cor_vld_d  = 1'b0;
      cor_xi     = {{(COR_W-4){cor_i[3]}}, cor_i};
      cor_yi     = {{(COR_W-4){cor_q[3]}}, cor_q};
      cor_zr     = cor_z_q + 8'd8;
      if (!cor_busy_q) begin
         if (cor_en) begin
            cor_busy_d = 1'b1;
            cor_step_d = 4'd0;
            if (cor_xi < 0) begin
               cor_x_d = -cor_xi;
               cor_y_d = -cor_yi;
               cor_z_d = 8'd128;
            end else begin
               cor_x_d = cor_xi;
               cor_y_d = cor_yi;
               cor_z_d = 8'd0;
            end
         end
      end else if (int'(cor_step_q) < CORDIC_ITER) begin
         if (cor_y_q >= 0) begin
            cor_x_d = cor_x_q + (cor_y_q >>> cor_step_q);
            cor_y_d = cor_y_q - (cor_x_q >>> cor_step_q);
            cor_z_d = cor_z_q + atan_lut(cor_step_q);
         end else begin
            cor_x_d = cor_x_q - (cor_y_q >>> cor_step_q);
            cor_y_d = cor_y_q + (cor_x_q >>> cor_step_q);
            cor_z_d = cor_z_q - atan_lut(cor_step_q);
         end
         cor_step_d = cor_step_q + 4'd1;
      end else begin
         cor_ph_d   = cor_zr[COR_W-1 -: PHASE_W];
         cor_vld_d  = 1'b1;
         cor_busy_d = 1'b0;
      end
   end

   always_ff @(posedge inClock) begin
      if (inReset) begin
         ser_state_q <= SER_IDLE;
         ser_sh_q    <= '0;
         ser_cnt_q   <= '0;
         cod_cnt_q   <= 1'b0;
         cod_first_q <= 1'b0;
         cod_eoc_q   <= 1'b0;
         cod_i_q     <= '0;
         cod_q_q     <= '0;
         dec_cnt_q   <= 1'b0;
         dec_vld_q   <= 1'b0;
         dec_hi_q    <= '0;
         dec_nib_q   <= '0;
         cor_busy_q  <= 1'b0;
         cor_vld_q   <= 1'b0;
         cor_step_q  <= '0;
         cor_x_q     <= '0;
         cor_y_q     <= '0;
         cor_z_q     <= '0;
         cor_ph_q    <= '0;
      end else begin
         ser_state_q <= ser_state_d;
         ser_sh_q    <= ser_sh_d;
         ser_cnt_q   <= ser_cnt_d;
         cod_cnt_q   <= cod_cnt_d;
         cod_first_q <= cod_first_d;
         cod_eoc_q   <= cod_eoc_d;
         cod_i_q     <= cod_i_d;
         cod_q_q     <= cod_q_d;
         dec_cnt_q   <= dec_cnt_d;
         dec_vld_q   <= dec_vld_d;
         dec_hi_q    <= dec_hi_d;
         dec_nib_q   <= dec_nib_d;
         cor_busy_q  <= cor_busy_d;
         cor_vld_q   <= cor_vld_d;
         cor_step_q  <= cor_step_d;
         cor_x_q     <= cor_x_d;
         cor_y_q     <= cor_y_d;
         cor_z_q     <= cor_z_d;
         cor_ph_q    <= cor_ph_d;
      end
   end

   // ---------------- observation muxes ----------------
   always_comb begin
      case (in_MUX_inSEL9)
         2'b00:   out_MUX_outMUX9 = in_dout;
         2'b01:   out_MUX_outMUX9 = cod_i_q;
         2'b10:   out_MUX_outMUX9 = dec_nib_q;
         default: out_MUX_outMUX9 = 4'd0;
      endcase
      case (in_MUX_inSEL6)
         2'b00:   out_MUX_outMUX10 = out_dout;
         2'b01:   out_MUX_outMUX10 = cod_q_q;
         2'b10:   out_MUX_outMUX10 = cor_ph_q;
         default: out_MUX_outMUX10 = 4'd0;
      endcase
      case (in_MUX_inSEL15)
         3'd0:    out_MUX_outMUX15 = in_empty;
         3'd1:    out_MUX_outMUX15 = cod_eoc_q;
         3'd2:    out_MUX_outMUX15 = cor_vld_q;
         3'd3:    out_MUX_outMUX15 = dec_vld_q;
         default: out_MUX_outMUX15 = 1'b0;
      endcase
      // coder busy = first bit of a pair captured, second still pending
      case ({in_MUX_inSEL12, in_MUX_inSEL11})
         2'b00:   out_MUX_outMUX16 = in_full;
         2'b01:   out_MUX_outMUX16 = out_empty;
         2'b10:   out_MUX_outMUX16 = out_full;
         default: out_MUX_outMUX16 = cod_cnt_q;
      endcase
   end

endmodule

// File: tb/tb_zigbee_top.sv
// Directed bench for zigbee_top. Strobed results (coder EOC, decoder valid,
// CORDIC valid) are pushed as expectations when stimulus is issued and popped
// by a monitor whenever the selected strobe on outMUX15 fires; level state
// (FIFO flags, FIFO data) is compared directly after the relevant cycle.
module tb_zigbee_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fifo_din;
   logic       out_re;
   logic       d1, d2;
   logic [3:0] d17, d18;
   logic [2:0] sel1, sel2, sel15;
   logic       sel3, sel17, sel11, sel12;
   logic [1:0] sel9, sel6;
   logic [3:0] mux9, mux10;
   logic       mux15, mux16;

   always #5 clk = ~clk;

   zigbee_top #(.FIFO_DEPTH(8), .CORDIC_ITER(4)) dut (
      .inClock(clk), .inReset(rst),
      .in_inFIFO_inData(fifo_din), .in_outFIFO_inReadEnable(out_re),
      .in_DEMUX_inDEMUX1(d1), .in_DEMUX_inDEMUX2(d2),
      .in_DEMUX_inDEMUX17(d17), .in_DEMUX_inDEMUX18(d18),
      .in_DEMUX_inSEL1(sel1), .in_DEMUX_inSEL2(sel2),
      .in_MUX_inSEL3(sel3), .in_DEMUX_inSEL17(sel17),
      .in_MUX_inSEL9(sel9), .in_MUX_inSEL6(sel6), .in_MUX_inSEL15(sel15),
      .in_MUX_inSEL11(sel11), .in_MUX_inSEL12(sel12),
      .out_MUX_outMUX9(mux9), .out_MUX_outMUX10(mux10),
      .out_MUX_outMUX15(mux15), .out_MUX_outMUX16(mux16)
   );

   typedef struct {
      string      name;
      logic       chk9;
      logic [3:0] e9;
      logic       chk10;
      logic [3:0] e10;
      int         ecyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic mon_en = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string n, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input string n, input logic c9, input logic [3:0] e9,
                           input logic c10, input logic [3:0] e10, input int ecyc);
      exp_t e;
      e.name = n; e.chk9 = c9; e.e9 = e9; e.chk10 = c10; e.e10 = e10; e.ecyc = ecyc;
      sb.push_back(e);
   endtask

   // monitor: one pending expectation per strobe pulse
   always @(negedge clk) begin
      if (mon_en && mux15 === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe at cycle %0d sel15=%0d", cyc, sel15);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk9)  cmp({mon_e.name, "_mux9"},  mux9,  mon_e.e9);
            if (mon_e.chk10) cmp({mon_e.name, "_mux10"}, mux10, mon_e.e10);
            if (mon_e.ecyc >= 0) begin
               checks++;
               if (cyc != mon_e.ecyc) begin
                  failures++;
                  $display("FAIL %s_latency actual_cycle=%0d expected_cycle=%0d",
                           mon_e.name, cyc, mon_e.ecyc);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string n, input int bound);
      int k = 0;
      while (sb.size() != 0 && k < bound) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout pending=%0d expected=0 after %0d cycles", n, sb.size(), bound);
         sb.delete();
      end
   endtask

   task automatic idle_inputs();
      fifo_din = 4'd0; out_re = 1'b0; d1 = 1'b0; d2 = 1'b0; d17 = 4'd0; d18 = 4'd0;
      sel1 = 3'd0; sel2 = 3'd0; sel3 = 1'b0; sel17 = 1'b0;
      sel9 = 2'd0; sel6 = 2'd0; sel15 = 3'd0; sel11 = 1'b0; sel12 = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      idle_inputs();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic flag16(input string n, input logic s12, input logic s11, input logic exp);
      sel12 = s12; sel11 = s11;
      #1 cmp(n, {3'b0, mux16}, {3'b0, exp});
   endtask

   task automatic flag15(input string n, input logic [2:0] s, input logic exp);
      sel15 = s;
      #1 cmp(n, {3'b0, mux15}, {3'b0, exp});
   endtask

   logic [3:0] t2_vals [3];

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(3);
      // ---- reset state (inReset still high) ----
      flag15("rst_in_empty", 3'd0, 1'b1);
      flag15("rst_cor_vld", 3'd2, 1'b0);
      flag16("rst_in_full", 1'b0, 1'b0, 1'b0);
      flag16("rst_out_empty", 1'b0, 1'b1, 1'b1);
      flag16("rst_out_full", 1'b1, 1'b0, 1'b0);
      sel9 = 2'b00; sel6 = 2'b00;
      #1 cmp("rst_in_dout", mux9, 4'b0000);
      cmp("rst_out_dout", mux10, 4'b0000);
      sel6 = 2'b10;
      #1 cmp("rst_phase", mux10, 4'b0000);
      idle_inputs();
      rst = 1'b0;
      tick(1);

      // ---- chained: 1101 flows end to end ----
      sel9 = 2'b10; sel15 = 3'd3; mon_en = 1'b1;
      push_exp("chain_dec", 1'b1, 4'b1101, 1'b0, 4'd0, -1);
      fifo_din = 4'b1101; d2 = 1'b1;
      tick(1);
      d2 = 1'b0;
      drain("chain", 30);
      tick(4);
      mon_en = 1'b0;
      flag15("chain_in_empty", 3'd0, 1'b1);
      flag16("chain_out_not_empty", 1'b0, 1'b1, 1'b0);
      out_re = 1'b1;
      tick(1);
      out_re = 1'b0;
      sel6 = 2'b00;
      #1 cmp("chain_out_dout", mux10, 4'b1101);
      flag16("chain_out_empty_after_pop", 1'b0, 1'b1, 1'b1);

      // ---- inFIFO standalone write/read ----
      do_reset();
      sel3 = 1'b1; sel1 = 3'b010; sel2 = 3'b000;
      t2_vals[0] = 4'b0001; t2_vals[1] = 4'b0100; t2_vals[2] = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         fifo_din = t2_vals[i]; d2 = 1'b1;
         tick(1);
      end
      d2 = 1'b0;
      flag15("fifo_not_empty", 3'd0, 1'b0);
      sel9 = 2'b00;
      for (int i = 0; i < 3; i++) begin
         d1 = 1'b1;
         tick(1);
         d1 = 1'b0;
         #1 cmp("fifo_pop", mux9, t2_vals[i]);
      end
      d1 = 1'b1;
      tick(1);
      d1 = 1'b0;
      #1 cmp("fifo_pop_empty_hold", mux9, 4'b1001);
      flag15("fifo_empty_after", 3'd0, 1'b1);

      // ---- coder standalone ----
      do_reset();
      d2 = 1'b1;
      sel3 = 1'b1; sel1 = 3'b001; sel2 = 3'b001;
      sel9 = 2'b01; sel6 = 2'b01; sel15 = 3'd1; mon_en = 1'b1;
      push_exp("coder_10", 1'b1, 4'b0111, 1'b1, 4'b1001, -1);
      d1 = 1'b1; d2 = 1'b0;
      tick(1);
      d1 = 1'b0;
      tick(1);
      d2 = 1'b1;
      drain("coder_10", 10);
      // pair split by an empty gap: first bit held until empty falls again
      push_exp("coder_split", 1'b1, 4'b1001, 1'b1, 4'b0111, -1);
      d1 = 1'b0; d2 = 1'b0;
      tick(1);
      d2 = 1'b1;
      tick(1);
      flag16("coder_busy_half_pair", 1'b1, 1'b1, 1'b1);
      tick(2);
      d1 = 1'b1; d2 = 1'b0;
      tick(1);
      d1 = 1'b0; d2 = 1'b1;
      drain("coder_split", 10);
      tick(4);
      mon_en = 1'b0;
      flag16("coder_idle_after", 1'b1, 1'b1, 1'b0);

      // ---- decoder standalone ----
      do_reset();
      sel3 = 1'b1; sel1 = 3'b000; sel17 = 1'b0;
      sel9 = 2'b10; sel15 = 3'd3; mon_en = 1'b1;
      push_exp("decoder", 1'b1, 4'b0100, 1'b0, 4'd0, -1);
      d17 = 4'b1010; d18 = 4'b0101; d1 = 1'b1;
      tick(1);
      d1 = 1'b0;
      tick(1);
      d17 = 4'b1110; d18 = 4'b1010; d1 = 1'b1;
      tick(1);
      d1 = 1'b0;
      drain("decoder", 10);
      tick(4);
      mon_en = 1'b0;
      flag16("decoder_wrote_outfifo", 1'b0, 1'b1, 1'b0);
      out_re = 1'b1;
      tick(1);
      out_re = 1'b0;
      sel6 = 2'b00;
      #1 cmp("decoder_outfifo_data", mux10, 4'b0100);

      // ---- CORDIC standalone ----
      do_reset();
      sel3 = 1'b1; sel2 = 3'b010; sel17 = 1'b1;
      sel6 = 2'b10; sel15 = 3'd2; mon_en = 1'b1;
      push_exp("cordic_q1", 1'b0, 4'd0, 1'b1, 4'd3, cyc + 6);
      d17 = 4'b0011; d18 = 4'b0110; d2 = 1'b1;
      tick(1);
      d2 = 1'b0;
      tick(1);
      // enable while busy must be ignored
      d17 = 4'b1101; d18 = 4'b1100; d2 = 1'b1;
      tick(1);
      d2 = 1'b0;
      drain("cordic_q1", 20);
      tick(8);
      push_exp("cordic_q3", 1'b0, 4'd0, 1'b1, 4'd10, cyc + 6);
      d17 = 4'b1101; d18 = 4'b1100; d2 = 1'b1;
      tick(1);
      d2 = 1'b0;
      drain("cordic_q3", 20);
      tick(8);
      mon_en = 1'b0;

      // ---- inFIFO fill: 9 writes, 9th dropped ----
      do_reset();
      sel3 = 1'b1; sel1 = 3'b010; sel2 = 3'b000;
      for (int i = 0; i < 9; i++) begin
         fifo_din = 4'(i + 1); d2 = 1'b1;
         tick(1);
         d2 = 1'b0;
         if (i == 6) flag16("fill_not_full_at7", 1'b0, 1'b0, 1'b0);
         if (i == 7) flag16("fill_full_at8", 1'b0, 1'b0, 1'b1);
      end
      flag16("fill_full_after9", 1'b0, 1'b0, 1'b1);
      sel9 = 2'b00;
      for (int i = 0; i < 8; i++) begin
         d1 = 1'b1;
         tick(1);
         d1 = 1'b0;
         #1 cmp("fill_read", mux9, 4'(i + 1));
      end
      flag15("fill_empty_after_reads", 3'd0, 1'b1);
      flag16("fill_not_full_after_reads", 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
